// File: rtl/spi_sram_bridge.sv
// rtl/spi_sram_bridge.sv - SPI slave parallel bus to asynchronous SRAM access bridge
//
// Takes the asynchronous strobe/bus interface of the SPI slave controller,
// synchronises read_n/write_n into clk and runs one timed SRAM cycle per strobe
// falling edge. Read data is returned on data_bus while the read strobe is held.
//
// Ports:
//   clk, reset_n       clock (posedge), synchronous active-low reset
//   address_bus        in     ADDR_W  access address (async domain)
//   data_bus           inout  DATA_W  write data in / read data out
//   read_n, write_n    in             async active-low access strobes
//   sram_addr          out    ADDR_W  SRAM address
//   sram_data          inout  DATA_W  SRAM data
//   sram_ce_n/oe_n/we_n out           SRAM controls, active low
//   busy               out            access running or pending
//   bus_err            out            sticky error (collision or overflow)
//   err_clr            in             clears bus_err
module spi_sram_bridge #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int WAIT_N = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address_bus,
    inout  logic [DATA_W-1:0] data_bus,
    input  logic              read_n,
    input  logic              write_n,
    output logic [ADDR_W-1:0] sram_addr,
    inout  logic [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              bus_err,
    input  logic              err_clr
);
    localparam int CNT_W = (WAIT_N > 1) ? $clog2(WAIT_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_N - 1);

    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // [0] first flop, [1] synchronised level, [2] previous synchronised level
    logic [2:0] rd_sync_q, wr_sync_q;

    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] cur_data_q, cur_data_d, pend_data_q, pend_data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              pend_q, pend_d, pend_wr_q, pend_wr_d;
    logic              rd_valid_q, rd_valid_d, bus_err_q, bus_err_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, sdrv_q, sdrv_d;

    logic rd_fall, wr_fall, rd_rise, collide, start, take_pend, take_new, err_set;

    assign rd_fall   = rd_sync_q[2] & ~rd_sync_q[1];
    assign wr_fall   = wr_sync_q[2] & ~wr_sync_q[1];
    assign rd_rise   = ~rd_sync_q[2] & rd_sync_q[1];
    assign collide   = rd_fall & wr_fall;
    assign start     = rd_fall ^ wr_fall;
    assign take_pend = (state_q == IDLE) && pend_q;
    assign take_new  = (state_q == IDLE) && !pend_q && start;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the pending slot always wins over a fresh start in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pend_q)     state_d = pend_wr_q ? WR_SETUP : RD_SETUP;
                else if (start) state_d = wr_fall ? WR_SETUP : RD_SETUP;
            end
            RD_SETUP: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end
            RD_WAIT: begin
                if (cnt_q == CNT_LAST) state_d = RD_DONE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            RD_DONE:  state_d = IDLE;
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = '0;
            end
            WR_PULSE: begin
                if (cnt_q == CNT_LAST) state_d = WR_HOLD;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            WR_HOLD:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode from the next state so the SRAM strobes come straight from
    // flops and line up with state_q without decode glitches.
    always_comb begin
        ce_n_d = (state_d == IDLE) || (state_d == RD_DONE);
        oe_n_d = (state_d != RD_WAIT);
        we_n_d = (state_d != WR_PULSE);
        sdrv_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
    end

    // Capture, pending slot, read return and error flag
    always_comb begin
        cur_addr_d  = cur_addr_q;
        cur_data_d  = cur_data_q;
        pend_d      = pend_q;
        pend_wr_d   = pend_wr_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        err_set     = collide;

        if (take_pend) begin
            cur_addr_d = pend_addr_q;
            cur_data_d = pend_data_q;
            pend_d     = 1'b0;
        end else if (take_new) begin
            cur_addr_d = address_bus;
            if (wr_fall) cur_data_d = data_bus;
        end

        // A start not served directly parks in the slot; the slot frees up in
        // the same cycle it is handed to the FSM, so it can be refilled then.
        if (start && !take_new) begin
            if (pend_q && !take_pend) begin
                err_set = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_wr_d   = wr_fall;
                pend_addr_d = address_bus;
                pend_data_d = data_bus;
            end
        end

        if ((state_q == RD_WAIT) && (cnt_q == CNT_LAST)) rd_data_d = sram_data;

        if (rd_rise || start)     rd_valid_d = 1'b0;
        if (state_q == RD_DONE)   rd_valid_d = 1'b1;

        bus_err_d = err_set | (bus_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_sync_q   <= '1;
            wr_sync_q   <= '1;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            pend_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            sdrv_q      <= 1'b0;
        end else begin
            rd_sync_q   <= {rd_sync_q[1:0], read_n};
            wr_sync_q   <= {wr_sync_q[1:0], write_n};
            cur_addr_q  <= cur_addr_d;
            cur_data_q  <= cur_data_d;
            pend_q      <= pend_d;
            pend_wr_q   <= pend_wr_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            bus_err_q   <= bus_err_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            sdrv_q      <= sdrv_d;
        end
    end

    assign sram_addr = cur_addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_data = sdrv_q ? cur_data_q : {DATA_W{1'bz}};
    assign data_bus  = (rd_valid_q && !rd_sync_q[1]) ? rd_data_q : {DATA_W{1'bz}};
    assign busy      = (state_q != IDLE) || pend_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_spi_sram_bridge.sv
// tb/tb_spi_sram_bridge.sv - directed self-checking bench for spi_sram_bridge
module tb_spi_sram_bridge;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] address_bus = '0;
    logic       read_n = 1'b1;
    logic       write_n = 1'b1;
    logic       err_clr = 1'b0;
    logic [6:0] sram_addr;
    logic       sram_ce_n, sram_oe_n, sram_we_n, busy, bus_err;

    // Released buses float high, so "not driven" reads as 8'hFF
    tri1 [7:0] data_bus;
    tri1 [7:0] sram_data;

    logic [7:0] spi_dout = '0;
    logic       spi_drive = 1'b0;
    assign data_bus = spi_drive ? spi_dout : 8'hzz;

    // Async SRAM model: drives on ce_n&oe_n low, writes on we_n rising with ce_n low
    logic [7:0] mem [0:127];
    logic       we_n_prev = 1'b1;
    logic       poke_en = 1'b0;
    logic [6:0] poke_addr = '0;
    logic [7:0] poke_data = '0;
    assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hzz;
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (!we_n_prev && sram_we_n && !sram_ce_n) mem[sram_addr] <= sram_data;
        we_n_prev <= sram_we_n;
    end

    spi_sram_bridge dut (
        .clk(clk), .reset_n(reset_n), .address_bus(address_bus), .data_bus(data_bus),
        .read_n(read_n), .write_n(write_n), .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .busy(busy), .bus_err(bus_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int we_cnt, ce_cnt, oe_cnt, lat, rel;
        logic [6:0] a;
        logic [7:0] d;

        // Reset state
        cyc(3);
        check("rst_ce_n", sram_ce_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_addr", sram_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_err", bus_err, 0);
        check("rst_data_bus", data_bus, 8'hFF);
        check("rst_sram_data", sram_data, 8'hFF);
        reset_n = 1'b1;
        cyc(3);

        // T1: single write, strobe held 50 clks
        address_bus = 7'h12; spi_dout = 8'h5A; spi_drive = 1'b1; write_n = 1'b0;
        we_cnt = 0; ce_cnt = 0;
        for (int i = 1; i <= 50; i++) begin
            cyc(1);
            if (i == 3) check("t1_busy", busy, 1);
            if (!sram_ce_n) ce_cnt++;
            if (!sram_we_n) begin
                we_cnt++;
                check("t1_we_addr", sram_addr, 7'h12);
                check("t1_we_data", sram_data, 8'h5A);
            end
        end
        check("t1_we_cycles", we_cnt, 2);
        check("t1_ce_cycles", ce_cnt, 4);
        write_n = 1'b1; spi_drive = 1'b0;
        cyc(4);
        check("t1_mem", mem[7'h12], 8'h5A);
        check("t1_idle", busy, 0);

        // T2: read back a preloaded value
        poke_addr = 7'h12; poke_data = 8'hA5; poke_en = 1'b1;
        cyc(1);
        poke_en = 1'b0;
        cyc(1);
        read_n = 1'b0;
        oe_cnt = 0; lat = 0;
        for (int i = 1; i <= 15; i++) begin
            cyc(1);
            if (!sram_oe_n) oe_cnt++;
            if (lat == 0 && data_bus == 8'hA5) lat = i;
        end
        check("t2_oe_cycles", oe_cnt, 2);
        check("t2_latency_ok", (lat >= 1 && lat <= 7), 1);
        check("t2_data", data_bus, 8'hA5);
        check("t2_addr", sram_addr, 7'h12);
        read_n = 1'b1;
        rel = 0;
        for (int j = 1; j <= 3; j++) begin
            cyc(1);
            if (rel == 0 && data_bus == 8'hFF) rel = j;
        end
        check("t2_release_ok", (rel >= 1), 1);
        cyc(3);

        // T3: both strobes fall in the same clk
        address_bus = 7'h40; read_n = 1'b0; write_n = 1'b0;
        ce_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (!sram_ce_n) ce_cnt++;
        end
        check("t3_no_access", ce_cnt, 0);
        check("t3_err_set", bus_err, 1);
        check("t3_no_data", data_bus, 8'hFF);
        read_n = 1'b1; write_n = 1'b1;
        cyc(4);
        check("t3_err_sticky", bus_err, 1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("t3_err_clr", bus_err, 0);
        cyc(2);

        // T4: read during write pulse is queued, third start overflows the slot
        address_bus = 7'h01; spi_dout = 8'h33; spi_drive = 1'b1; write_n = 1'b0;
        we_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (!sram_we_n) we_cnt++;
            if (i == 2) begin read_n = 1'b0; write_n = 1'b1; end
            if (i == 3) begin write_n = 1'b0; spi_dout = 8'h77; end
            if (i == 6) begin
                check("t4_overflow_err", bus_err, 1);
                spi_drive = 1'b0;
            end
            if (i == 7) begin
                check("t4_pending_busy", busy, 1);
                check("t4_hold_done_ce", sram_ce_n, 1);
            end
            if (i == 8) begin
                check("t4_rd_start_ce", sram_ce_n, 0);
                check("t4_rd_start_we", sram_we_n, 1);
                check("t4_rd_addr", sram_addr, 7'h01);
            end
            if (i == 9) check("t4_rd_oe", sram_oe_n, 0);
            if (i == 12) check("t4_rd_data", data_bus, 8'h33);
        end
        check("t4_one_write", we_cnt, 2);
        check("t4_mem", mem[7'h01], 8'h33);
        read_n = 1'b1; write_n = 1'b1;
        cyc(5);
        check("t4_idle", busy, 0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;

        // T5: reset during write pulse
        address_bus = 7'h05; spi_dout = 8'h44; spi_drive = 1'b1; write_n = 1'b0;
        cyc(4);
        check("t5_in_pulse", sram_we_n, 0);
        reset_n = 1'b0;
        cyc(1);
        check("t5_we_n", sram_we_n, 1);
        check("t5_ce_n", sram_ce_n, 1);
        check("t5_sram_data", sram_data, 8'hFF);
        check("t5_busy", busy, 0);
        reset_n = 1'b1; write_n = 1'b1; spi_drive = 1'b0;
        ce_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (!sram_ce_n) ce_cnt++;
        end
        check("t5_no_restart", ce_cnt, 0);

        // T6: strobes at random phase to clk
        for (int k = 0; k < 6; k++) begin
            a = 7'h20 + 7'(k);
            d = 8'h11 * 8'(k + 1);
            @(negedge clk); #(1 + $urandom_range(0, 8));
            address_bus = a; spi_dout = d; spi_drive = 1'b1; write_n = 1'b0;
            we_cnt = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (!sram_we_n) we_cnt++;
            end
            #(1 + $urandom_range(0, 8));
            write_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (!sram_we_n) we_cnt++;
            end
            spi_drive = 1'b0;
            check("t6_wr_once", we_cnt, 2);
            check("t6_no_x", $isunknown({sram_ce_n, sram_oe_n, sram_we_n, busy, bus_err, sram_addr}), 0);
        end
        for (int k = 0; k < 6; k++) begin
            a = 7'h20 + 7'(k);
            d = 8'h11 * 8'(k + 1);
            @(negedge clk); #(1 + $urandom_range(0, 8));
            address_bus = a; read_n = 1'b0;
            oe_cnt = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (!sram_oe_n) oe_cnt++;
            end
            check("t6_rd_data", data_bus, {24'h0, d});
            #(1 + $urandom_range(0, 8));
            read_n = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (!sram_oe_n) oe_cnt++;
            end
            check("t6_rd_once", oe_cnt, 2);
            check("t6_rd_release", data_bus, 8'hFF);
        end
        check("t6_err_clean", bus_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
